reset_entry_seq: RTL and testbench
==================================

// Module: reset_entry_seq
// PURPOSE
//   Reset/clock-gate sequencer for one gated sub-domain. Runs a power-down
//   (entry) sequence and the matching wake (release) sequence:
//   - Entry: drain, assert the domain reset while the clock runs, then gate the clock.
//   - Wake: ungate the clock with reset held, then release the reset.
//   It uses a 4-phase req/ack handshake with the power controller and sits
//   between that controller and the domain's clock gate and reset tree.
// PARAMETERS
//   GATE_DLY      4   cycles between clock-enable change and reset change (both directions), >=1
//   RST_HOLD      8   cycles domain reset held with clock running on entry, >=1
//   IDLE_TIMEOUT  16  max cycles waiting for idle_i before forcing reset, >=1
// PORTS
//   clk           in   1  single clock, rising edge
//   reset_n       in   1  asynchronous, active-low reset
//   pd_req_i      in   1  level: 1 = put domain in reset/gated, 0 = run
//   idle_i        in   1  domain reports no outstanding traffic
//   domain_rst_o  out  1  active-high reset to domain
//   clk_en_o      out  1  clock-gate enable for domain clock
//   pd_ack_o      out  1  1 = domain held in reset with clock gated
//   timeout_o     out  1  sticky: last entry was forced by idle timeout
// BEHAVIOUR
//   - All outputs are registered: they decode the state register, with no comb path from inputs.
//   - reset_n low puts the block in state HELD immediately (async):
//     domain_rst_o=1, clk_en_o=0, pd_ack_o=1, timeout_o=0, cnt=0.
//   - States (rst / en / ack) and transitions:
//     HELD   (1/0/1): pd_req_i==0 -> WAKE, cnt=0; else stay.
//     WAKE   (1/1/1): exactly GATE_DLY cycles, then -> RUN. pd_req_i ignored here.
//     RUN    (0/1/0): pd_req_i==1 -> DRAIN, cnt=0, timeout_o cleared.
//     DRAIN  (0/1/0): evaluated in this order each cycle:
//       - pd_req_i==0 -> RUN (abort, reset never asserted).
//       - else idle_i==1 -> ASSERT.
//       - else cnt==IDLE_TIMEOUT-1 -> ASSERT, timeout_o<=1.
//       - else cnt++.
//     ASSERT (1/1/0): exactly RST_HOLD cycles, then -> GATE.
//     GATE   (1/0/0): exactly GATE_DLY cycles, then -> HELD.
//   - Once ASSERT is entered, entry always completes to HELD.
//     A pd_req_i drop during ASSERT/GATE is honoured only from HELD: one cycle in HELD, then WAKE.
//   - A pd_req_i rise during WAKE is honoured only from RUN: one cycle in RUN, then DRAIN.
//   - Handshake: ack rises on the first HELD cycle and falls on the first RUN cycle.
//     Requester keeps pd_req_i stable until ack matches.
//   - Ordering invariants, checked every cycle:
//     - clk_en_o and domain_rst_o never change in the same cycle.
//     - clk_en_o==0 implies domain_rst_o==1.
//   - cnt width = $clog2(max(GATE_DLY,RST_HOLD,IDLE_TIMEOUT))+1.
//     cnt resets to 0 on every state change and never wraps.
//   - timeout_o holds until the next RUN->DRAIN transition or reset_n.
//   - Unused state encodings -> HELD.
// TESTING
//   1. reset_n low, pd_req_i=0: outputs 1/0/1 during reset. After release:
//      - clk_en_o=1 after 1 cycle.
//      - domain_rst_o and pd_ack_o fall 4 cycles later (GATE_DLY=4).
//   2. RUN, idle_i=1, pd_req_i rises: DRAIN for 1 cycle, then:
//      - domain_rst_o=1 with clk_en_o=1 for 8 cycles.
//      - then clk_en_o=0.
//      - pd_ack_o=1 after 4 more cycles. timeout_o stays 0.
//   3. idle_i held 0, pd_req_i=1: exactly 16 DRAIN cycles, then ASSERT with timeout_o=1.
//      timeout_o stays 1 through HELD/WAKE/RUN and clears on the next DRAIN.
//   4. pd_req_i pulses 1 for 3 cycles with idle_i=0: returns to RUN.
//      domain_rst_o never asserts, pd_ack_o stays 0.
//   5. reset_n pulsed low in the 3rd ASSERT cycle: outputs go 1/0/1 without waiting
//      for a clock edge. timeout_o=0. Then the normal wake runs if pd_req_i=0.
//   6. pd_req_i dropped during GATE: GATE completes, HELD lasts 1 cycle, then WAKE.
//      Invariants from BEHAVIOUR are asserted across all scenarios.

Source files
------------

// File: rtl/reset_entry_seq.sv
// Reset/clock-gate sequencer for one gated sub-domain.
// Handles power-down entry (drain, reset, gate) and wake (ungate, release) with a req/ack handshake.
module reset_entry_seq #(
   parameter int GATE_DLY     = 4,
   parameter int RST_HOLD     = 8,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pd_req_i,
   input  logic idle_i,
   output logic domain_rst_o,
   output logic clk_en_o,
   output logic pd_ack_o,
   output logic timeout_o
);

   localparam int MAX_AB  = (GATE_DLY > RST_HOLD) ? GATE_DLY : RST_HOLD;
   localparam int MAX_DLY = (MAX_AB > IDLE_TIMEOUT) ? MAX_AB : IDLE_TIMEOUT;
   localparam int CW      = $clog2(MAX_DLY) + 1;

   localparam logic [CW-1:0] GATE_LAST = CW'(GATE_DLY - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_HELD   = 3'd0,
      S_WAKE   = 3'd1,
      S_RUN    = 3'd2,
      S_DRAIN  = 3'd3,
      S_ASSERT = 3'd4,
      S_GATE   = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            r_timeout;
   logic            w_timeout_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_HELD;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_timeout <= w_timeout_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_timeout_next = r_timeout;
      case (r_state)
         S_HELD: begin
            if (!pd_req_i) w_state_next = S_WAKE;
         end
         S_WAKE: begin
            if (r_cnt == GATE_LAST) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (pd_req_i) begin
               w_state_next   = S_DRAIN;
               w_timeout_next = 1'b0;
            end
         end
         S_DRAIN: begin
            // Abort beats idle, idle beats timeout.
            if (!pd_req_i) begin
               w_state_next = S_RUN;
            end else if (idle_i) begin
               w_state_next = S_ASSERT;
            end else if (r_cnt == IDLE_LAST) begin
               w_state_next   = S_ASSERT;
               w_timeout_next = 1'b1;
            end
         end
         S_ASSERT: begin
            if (r_cnt == HOLD_LAST) w_state_next = S_GATE;
         end
         S_GATE: begin
            if (r_cnt == GATE_LAST) w_state_next = S_HELD;
         end
         default: w_state_next = S_HELD;
      endcase

      // Counter restarts on every state change and saturates instead of wrapping.
      if (w_state_next != r_state) begin
         w_cnt_next = '0;
      end else if (r_cnt != {CW{1'b1}}) begin
         w_cnt_next = r_cnt + 1'b1;
      end else begin
         w_cnt_next = r_cnt;
      end
   end

   always_comb begin
      domain_rst_o = 1'b1;
      clk_en_o     = 1'b0;
      pd_ack_o     = 1'b1;
      case (r_state)
         S_HELD: begin
            domain_rst_o = 1'b1; clk_en_o = 1'b0; pd_ack_o = 1'b1;
         end
         S_WAKE: begin
            domain_rst_o = 1'b1; clk_en_o = 1'b1; pd_ack_o = 1'b1;
         end
         S_RUN, S_DRAIN: begin
            domain_rst_o = 1'b0; clk_en_o = 1'b1; pd_ack_o = 1'b0;
         end
         S_ASSERT: begin
            domain_rst_o = 1'b1; clk_en_o = 1'b1; pd_ack_o = 1'b0;
         end
         S_GATE: begin
            domain_rst_o = 1'b1; clk_en_o = 1'b0; pd_ack_o = 1'b0;
         end
         default: begin
            domain_rst_o = 1'b1; clk_en_o = 1'b0; pd_ack_o = 1'b1;
         end
      endcase
   end

   assign timeout_o = r_timeout;

endmodule

// File: tb/tb_reset_entry_seq.sv
// Directed table-driven bench for reset_entry_seq with a per-cycle ordering monitor.
// Expected output word is {domain_rst_o, clk_en_o, pd_ack_o, timeout_o}.
module tb_reset_entry_seq;

   logic clk;
   logic reset_n;
   logic pd_req_i;
   logic idle_i;
   logic domain_rst_o;
   logic clk_en_o;
   logic pd_ack_o;
   logic timeout_o;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic       rn;
      logic       req;
      logic       idle;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];

   reset_entry_seq #(
      .GATE_DLY(4),
      .RST_HOLD(8),
      .IDLE_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pd_req_i(pd_req_i),
      .idle_i(idle_i),
      .domain_rst_o(domain_rst_o),
      .clk_en_o(clk_en_o),
      .pd_ack_o(pd_ack_o),
      .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [3:0] exp);
      logic [3:0] act;
      act = {domain_rst_o, clk_en_o, pd_ack_o, timeout_o};
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: rst/en/ack/to got %b expected %b", name, idx, act, exp);
      end else begin
         $display("ok   %s[%0d]: rst/en/ack/to = %b", name, idx, act);
      end
   endtask

   task automatic addn(input int n, input logic rn, input logic req, input logic idle,
                       input logic [3:0] exp);
      vec_t v;
      v.rn = rn; v.req = req; v.idle = idle; v.exp = exp;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   // Inputs change at posedge+1; outputs checked at the following posedge+1.
   task automatic step(input string name, input int idx, input logic rn, input logic req,
                       input logic idle, input logic [3:0] exp);
      reset_n  = rn;
      pd_req_i = req;
      idle_i   = idle;
      @(posedge clk);
      #1;
      chk(name, idx, exp);
   endtask

   // Ordering invariants, sampled on the falling edge.
   logic       prev_valid;
   logic       prev_rst;
   logic       prev_en;
   initial prev_valid = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_valid <= 1'b0;
      end else begin
         n_cmp++;
         if (!clk_en_o && !domain_rst_o) begin
            n_fail++;
            $display("FAIL gated_implies_rst @%0t: en=%b rst=%b required rst=1", $time,
                     clk_en_o, domain_rst_o);
         end
         if (prev_valid) begin
            n_cmp++;
            if ((clk_en_o != prev_en) && (domain_rst_o != prev_rst)) begin
               n_fail++;
               $display("FAIL same_cycle_change @%0t: en %b->%b rst %b->%b required one at a time",
                        $time, prev_en, clk_en_o, prev_rst, domain_rst_o);
            end
         end
         prev_valid <= 1'b1;
         prev_en    <= clk_en_o;
         prev_rst   <= domain_rst_o;
      end
   end

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      pd_req_i = 1'b0;
      idle_i   = 1'b0;
      reset_n  = 1'b1;
      #1 reset_n = 1'b0;
      #1 chk("async_reset_t0", 0, 4'b1010);

      // Wake from reset, then idle entry, wake, timeout entry, wake, aborted drain, gate-drop.
      addn(2,  1'b0, 1'b0, 1'b0, 4'b1010);
      addn(4,  1'b1, 1'b0, 1'b0, 4'b1110);
      addn(2,  1'b1, 1'b0, 1'b0, 4'b0100);
      addn(1,  1'b1, 1'b1, 1'b1, 4'b0100);
      addn(8,  1'b1, 1'b1, 1'b1, 4'b1100);
      addn(4,  1'b1, 1'b1, 1'b1, 4'b1000);
      addn(3,  1'b1, 1'b1, 1'b1, 4'b1010);
      addn(4,  1'b1, 1'b0, 1'b1, 4'b1110);
      addn(2,  1'b1, 1'b0, 1'b1, 4'b0100);
      addn(16, 1'b1, 1'b1, 1'b0, 4'b0100);
      addn(8,  1'b1, 1'b1, 1'b0, 4'b1101);
      addn(4,  1'b1, 1'b1, 1'b0, 4'b1001);
      addn(2,  1'b1, 1'b1, 1'b0, 4'b1011);
      addn(4,  1'b1, 1'b0, 1'b0, 4'b1111);
      addn(2,  1'b1, 1'b0, 1'b0, 4'b0101);
      addn(3,  1'b1, 1'b1, 1'b0, 4'b0100);
      addn(3,  1'b1, 1'b0, 1'b0, 4'b0100);
      addn(1,  1'b1, 1'b1, 1'b1, 4'b0100);
      addn(8,  1'b1, 1'b1, 1'b1, 4'b1100);
      addn(1,  1'b1, 1'b1, 1'b1, 4'b1000);
      addn(3,  1'b1, 1'b0, 1'b1, 4'b1000);
      addn(1,  1'b1, 1'b0, 1'b1, 4'b1010);
      addn(4,  1'b1, 1'b0, 1'b1, 4'b1110);
      addn(2,  1'b1, 1'b0, 1'b1, 4'b0100);

      @(posedge clk);
      #1;
      foreach (vecs[i]) step("table", i, vecs[i].rn, vecs[i].req, vecs[i].idle, vecs[i].exp);

      // Timeout entry interrupted by reset_n in the third ASSERT cycle.
      for (int i = 0; i < 16; i++) step("s5_drain", i, 1'b1, 1'b1, 1'b0, 4'b0100);
      for (int i = 0; i < 3; i++)  step("s5_assert", i, 1'b1, 1'b1, 1'b0, 4'b1101);
      #2 reset_n = 1'b0;
      #1 chk("s5_async", 0, 4'b1010);
      @(posedge clk);
      #1 chk("s5_held_in_reset", 0, 4'b1010);
      step("s5_wake", 0, 1'b1, 1'b0, 1'b0, 4'b1110);
      for (int i = 1; i < 4; i++) step("s5_wake", i, 1'b1, 1'b0, 1'b0, 4'b1110);
      step("s5_run", 0, 1'b1, 1'b0, 1'b0, 4'b0100);
      step("s5_run", 1, 1'b1, 1'b0, 1'b0, 4'b0100);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
